// File: rtl/pipeline_run_controller.sv
// Run/reset sequencer for the pipelined MIPS core: holds the core in reset,
// runs it for a bounded window, and folds its result bus into a MISR signature.
module pipeline_run_controller #(
  parameter int                DATA_W       = 32,
  parameter int                CNT_W        = 16,
  parameter int                RESET_CYCLES = 2,
  parameter int                RUN_CYCLES   = 64,
  parameter logic [DATA_W-1:0] POLY         = 32'h04C11DB7,
  parameter logic [DATA_W-1:0] EXPECT_SIG   = 32'h00000000,
  parameter bit                STOP_EN      = 1'b0,
  parameter logic [DATA_W-1:0] STOP_VALUE   = 32'hFFFFFFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] result,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [DATA_W-1:0] signature
);

  // state | meaning
  // IDLE  | waiting for start, core held in reset
  // HOLD  | core held in reset for RESET_CYCLES cycles
  // RUN   | core released, result folded into signature each cycle
  // DONE  | run finished, results held, core back in reset
  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  hold_cnt;
  logic [DATA_W-1:0] sig_next;
  logic              stop_hit;
  logic              run_last;

  always_comb begin
    sig_next = {signature[DATA_W-2:0], 1'b0} ^ (signature[DATA_W-1] ? POLY : '0) ^ result;
    stop_hit = STOP_EN && (result == STOP_VALUE);
    run_last = (cycle_count == RUN_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      signature   <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      // results stay visible after an abort for post-mortem inspection
      state      <= IDLE;
      core_reset <= 1'b1;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            cycle_count <= '0;
            signature   <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
          end
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end
        end
        RUN: begin
          signature   <= sig_next;
          cycle_count <= cycle_count + 1'b1;
          if (stop_hit || run_last) begin
            state      <= DONE;
            pass       <= (sig_next == EXPECT_SIG);
            timeout    <= STOP_EN && !stop_hit;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          core_reset <= 1'b1;
          running    <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Scoreboard bench: one instance without early stop, one with the sentinel enabled.
module tb_pipeline_run_controller;
  localparam int          DW    = 32;
  localparam int          CW    = 16;
  localparam int          RSTC  = 2;
  localparam int          RUNS  = 4;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] SENT  = 32'hFFFFFFFF;
  localparam logic [31:0] EXP_A = 32'h00000000;
  localparam logic [31:0] EXP_B = 32'hFFFFFFF9;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b1;
  logic          start_a = 1'b0, start_b = 1'b0, abort_a = 1'b0, abort_b = 1'b0;
  logic [DW-1:0] result = '0;
  logic          core_reset_a, running_a, done_a, pass_a, timeout_a;
  logic          core_reset_b, running_b, done_b, pass_b, timeout_b;
  logic [CW-1:0] cycle_count_a, cycle_count_b;
  logic [DW-1:0] signature_a, signature_b;

  pipeline_run_controller #(
    .DATA_W(DW), .CNT_W(CW), .RESET_CYCLES(RSTC), .RUN_CYCLES(RUNS), .POLY(POLY),
    .EXPECT_SIG(EXP_A), .STOP_EN(1'b0), .STOP_VALUE(SENT)
  ) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .abort(abort_a), .result(result),
    .core_reset(core_reset_a), .running(running_a), .done(done_a), .pass(pass_a),
    .timeout(timeout_a), .cycle_count(cycle_count_a), .signature(signature_a)
  );

  pipeline_run_controller #(
    .DATA_W(DW), .CNT_W(CW), .RESET_CYCLES(RSTC), .RUN_CYCLES(RUNS), .POLY(POLY),
    .EXPECT_SIG(EXP_B), .STOP_EN(1'b1), .STOP_VALUE(SENT)
  ) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort_b), .result(result),
    .core_reset(core_reset_b), .running(running_b), .done(done_b), .pass(pass_b),
    .timeout(timeout_b), .cycle_count(cycle_count_b), .signature(signature_b)
  );

  typedef struct packed {
    logic          core_reset;
    logic          running;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [CW-1:0] cnt;
    logic [DW-1:0] sig;
  } obs_t;

  typedef struct {
    logic [DW-1:0] sig;
    logic [CW-1:0] cnt;
    logic          pass;
    logic          tmo;
    int            hold;
    int            run;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] stim[$];
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] r);
    return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ r;
  endfunction

  function automatic obs_t obs(input bit b);
    obs_t o;
    if (b) o = '{core_reset_b, running_b, done_b, pass_b, timeout_b, cycle_count_b, signature_b};
    else   o = '{core_reset_a, running_a, done_a, pass_a, timeout_a, cycle_count_a, signature_a};
    return o;
  endfunction

  function automatic logic [31:0] stim_at(input int i);
    return stim[(i < stim.size()) ? i : stim.size() - 1];
  endfunction

  task automatic set_start(input bit b, input logic v);
    if (b) start_b = v;
    else   start_a = v;
  endtask

  // Full run: model pushes the expectation, DUT completion pops and compares.
  task automatic do_run(input bit b, input bit poke);
    exp_t        e;
    obs_t        o;
    logic [31:0] s = '0;
    logic [31:0] r = '0;
    int          c = 0;
    int          hs = 0;
    int          rs = 0;
    bit          fin = 0;
    bit          got_done = 0;
    while (!fin) begin
      r = stim_at(c);
      s = misr(s, r);
      c++;
      fin = (b && r == SENT) || c == RUNS;
    end
    e.sig  = s;
    e.cnt  = CW'(c);
    e.pass = (s == (b ? EXP_B : EXP_A));
    e.tmo  = b && (r != SENT);
    e.hold = RSTC;
    e.run  = c;
    sb.push_back(e);

    @(negedge clock); set_start(b, 1'b1);
    @(negedge clock); set_start(b, 1'b0);
    for (int k = 0; k < 40; k++) begin
      o = obs(b);
      if (o.done) begin
        got_done = 1;
        break;
      end
      if (o.running) begin
        result = stim_at(rs);
        rs++;
      end else if (o.core_reset) begin
        hs++;
      end
      set_start(b, poke && (hs == 1 && rs == 0 || rs == 2));
      @(negedge clock);
    end
    set_start(b, 1'b0);
    chk("done_reached", got_done, 1);
    e = sb.pop_front();
    o = obs(b);
    chk("signature", o.sig, e.sig);
    chk("cycle_count", o.cnt, e.cnt);
    chk("pass", o.pass, e.pass);
    chk("timeout", o.timeout, e.tmo);
    chk("hold_cycles", hs, e.hold);
    chk("run_cycles", rs, e.run);
    chk("done_core_reset", o.core_reset, 1);
    chk("done_running", o.running, 0);
  endtask

  // Start a run and return at the negedge where the given HOLD/RUN cycle is reached.
  task automatic start_to(input bit b, input int hold_n, input int run_n);
    obs_t o;
    int   hs = 0;
    int   rs = 0;
    bit   hit = 0;
    @(negedge clock); set_start(b, 1'b1);
    @(negedge clock); set_start(b, 1'b0);
    for (int k = 0; k < 40; k++) begin
      o = obs(b);
      if (o.running) begin
        result = stim_at(rs);
        rs++;
      end else if (o.core_reset) begin
        hs++;
      end
      if ((hold_n > 0 && hs == hold_n && rs == 0) || (run_n > 0 && rs == run_n)) begin
        hit = 1;
        break;
      end
      @(negedge clock);
    end
    chk("reach_point", hit, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    obs_t o;
    o = obs(0);
    chk({tag, "_core_reset"}, o.core_reset, 1);
    chk({tag, "_running"}, o.running, 0);
    chk({tag, "_done"}, o.done, 0);
    chk({tag, "_pass"}, o.pass, 0);
    chk({tag, "_timeout"}, o.timeout, 0);
    chk({tag, "_count"}, o.cnt, 0);
    chk({tag, "_sig"}, o.sig, 0);
  endtask

  initial begin
    obs_t o;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk_reset_state("por");

    stim = '{32'h1};
    do_run(0, 0);
    chk("sig_const_F", signature_a, 32'h0000000F);
    do_run(0, 0);

    stim = '{32'h0};
    do_run(0, 0);
    chk("pass_on_zero", pass_a, 1);

    stim = '{32'h1, 32'h1, SENT};
    do_run(1, 0);
    chk("sig_sentinel", signature_b, 32'hFFFFFFF9);
    chk("cnt_sentinel", cycle_count_b, 3);

    stim = '{32'h1};
    do_run(1, 0);
    chk("timeout_set", timeout_b, 1);

    stim = '{32'h3, 32'h8000_0000, 32'h7, 32'h10};
    do_run(0, 1);

    stim = '{32'h5, 32'h9};
    start_to(0, 0, 2);
    abort_a = 1'b1;
    @(negedge clock);
    abort_a = 1'b0;
    o = obs(0);
    chk("abort_core_reset", o.core_reset, 1);
    chk("abort_running", o.running, 0);
    chk("abort_done", o.done, 0);
    chk("abort_count", o.cnt, 1);
    chk("abort_sig", o.sig, 32'h5);
    do_run(0, 0);

    stim = '{32'h1234_5678};
    start_to(0, 1, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_reset_state("rst_hold");
    start_to(0, 0, 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk_reset_state("rst_run");

    result = '0;
    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
